// File: rtl/vga_syncgen_pkg.sv
// Shared VGA 640x480@60 timing constants, counter type and range helper for vga_syncgen.
// The optional frame-start strobe of the top is controlled by VGA_SYNCGEN_FSTART_EN.
package vga_timing_pkg;

    localparam int CNT_W      = 10;
    localparam int MAX_PERIOD = 1 << CNT_W;

    localparam int H_PERIOD = 800;
    localparam int H_FRONT  = 16;
    localparam int H_WIDTH  = 96;
    localparam int H_BACK   = 48;

    localparam int V_PERIOD = 525;
    localparam int V_FRONT  = 10;
    localparam int V_WIDTH  = 2;
    localparam int V_BACK   = 33;

    typedef logic [CNT_W-1:0] cnt_t;

    // Half-open window test [lo, hi) on an unsigned counter value.
    function automatic logic inRange(cnt_t value, int lo, int hi);
        return (int'(value) >= lo) && (int'(value) < hi);
    endfunction

endpackage

// File: rtl/vga_syncgen_if.sv
// One timing axis as seen by the sync generator top: counter, registered sync level,
// wrap strobe and the active decode of the counter's next value.
interface vga_syncgen_if;
    import vga_timing_pkg::*;

    cnt_t cnt;
    logic syncN;
    logic wrap;
    logic activeNext;

    modport master (output cnt, syncN, wrap, activeNext);
    modport slave  (input  cnt, syncN, wrap, activeNext);

endinterface

// File: rtl/vga_syncgen_axis.sv
// One axis of the VGA timing: enabled wrap counter with a sync level registered from the
// counter's next value, so sync lines up with the counter in the same cycle.
module syncgen_axis
    import vga_timing_pkg::*;
#(
    parameter int PERIOD     = H_PERIOD,
    parameter int ACT        = H_PERIOD - H_FRONT - H_WIDTH - H_BACK,
    parameter int SYNC_START = ACT + H_FRONT,
    parameter int SYNC_END   = SYNC_START + H_WIDTH
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          en_i,
    vga_syncgen_if.master axis
);

    localparam cnt_t LAST = cnt_t'(PERIOD - 1);

    cnt_t cnt_q;
    cnt_t cnt_d;
    logic syncN_q;
    logic syncN_d;
    logic wrap;

    always_comb begin
        wrap    = en_i && (cnt_q == LAST);
        cnt_d   = cnt_q;
        if (wrap) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + cnt_t'(1);
        end
        syncN_d = !inRange(cnt_d, SYNC_START, SYNC_END);
    end

    // Reset parks the counter on its last value so the first enabled edge lands on zero.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q   <= LAST;
            syncN_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            syncN_q <= syncN_d;
        end
    end

    assign axis.cnt        = cnt_q;
    assign axis.syncN      = syncN_q;
    assign axis.wrap       = wrap;
    assign axis.activeNext = (int'(cnt_d) < ACT);

endmodule

// File: rtl/vga_syncgen.sv
// VGA sync generator: horizontal/vertical counters, active-low syncs and display enable.
// Defining VGA_SYNCGEN_FSTART_EN adds the registered FSTART frame-start strobe.
module vga_syncgen
    import vga_timing_pkg::*;
#(
    parameter int HPERIOD = H_PERIOD,
    parameter int HFRONT  = H_FRONT,
    parameter int HWIDTH  = H_WIDTH,
    parameter int HBACK   = H_BACK,
    parameter int VPERIOD = V_PERIOD,
    parameter int VFRONT  = V_FRONT,
    parameter int VWIDTH  = V_WIDTH,
    parameter int VBACK   = V_BACK
) (
    input  logic             PCK,
    input  logic             RSTN,
    output logic [CNT_W-1:0] HCNT,
    output logic [CNT_W-1:0] VCNT,
    output logic             HSYNC,
    output logic             VSYNC,
    output logic             DE
`ifdef VGA_SYNCGEN_FSTART_EN
    ,
    output logic             FSTART
`endif
);

    localparam int HACT = HPERIOD - HFRONT - HWIDTH - HBACK;
    localparam int VACT = VPERIOD - VFRONT - VWIDTH - VBACK;

    if (HPERIOD > MAX_PERIOD || VPERIOD > MAX_PERIOD || HACT <= 0 || VACT <= 0) begin : g_badTiming
        $error("vga_syncgen: periods must be <= %0d and leave a non-empty visible area", MAX_PERIOD);
    end

    vga_syncgen_if hAxis ();
    vga_syncgen_if vAxis ();

    syncgen_axis #(
        .PERIOD     (HPERIOD),
        .ACT        (HACT),
        .SYNC_START (HACT + HFRONT),
        .SYNC_END   (HACT + HFRONT + HWIDTH)
    ) u_hAxis (
        .clk  (PCK),
        .rstn (RSTN),
        .en_i (1'b1),
        .axis (hAxis.master)
    );

    syncgen_axis #(
        .PERIOD     (VPERIOD),
        .ACT        (VACT),
        .SYNC_START (VACT + VFRONT),
        .SYNC_END   (VACT + VFRONT + VWIDTH)
    ) u_vAxis (
        .clk  (PCK),
        .rstn (RSTN),
        .en_i (hAxis.wrap),
        .axis (vAxis.master)
    );

    logic de_q;
    logic de_d;

    // DE is registered from both next-state decodes rather than ANDing two flop outputs.
    assign de_d = hAxis.activeNext && vAxis.activeNext;

    always_ff @(posedge PCK) begin
        if (!RSTN) begin
            de_q <= 1'b0;
        end else begin
            de_q <= de_d;
        end
    end

    assign HCNT  = hAxis.cnt;
    assign VCNT  = vAxis.cnt;
    assign HSYNC = hAxis.syncN;
    assign VSYNC = vAxis.syncN;
    assign DE    = de_q;

`ifdef VGA_SYNCGEN_FSTART_EN
    logic fstart_q;
    logic fstart_d;

    // Both axes wrapping on the same edge is exactly the step onto HCNT = 0, VCNT = 0.
    assign fstart_d = hAxis.wrap && vAxis.wrap;

    always_ff @(posedge PCK) begin
        if (!RSTN) begin
            fstart_q <= 1'b0;
        end else begin
            fstart_q <= fstart_d;
        end
    end

    assign FSTART = fstart_q;
`endif

endmodule
